// File: rtl/coeff_bank_loader_if.sv
// Coefficient stream in / bank write bus out for coeff_bank_loader.
//   in_valid, in_data : upstream coefficient stream (driven by master)
//   in_ready_c        : loader can accept; combinational from loader state
//   sel, bank_data,
//   bank_we, bank_addr: registered demux select, data, one-hot strobe, word address
// slave  = loader view, master = feeder/consumer (bench) view.
interface coeff_bank_loader_if #(
    parameter int unsigned N     = 9,
    parameter int unsigned S     = 3,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned SW = $clog2(S);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready_c;
    logic [SW-1:0] sel;
    logic [N-1:0]  bank_data;
    logic [S-1:0]  bank_we;
    logic [AW-1:0] bank_addr;

    modport slave (
        input  in_valid, in_data,
        output in_ready_c, sel, bank_data, bank_we, bank_addr
    );

    modport master (
        output in_valid, in_data,
        input  in_ready_c, sel, bank_data, bank_we, bank_addr
    );
endinterface

// File: rtl/coeff_bank_loader.sv
// Round-robin loader: distributes one polynomial of S*DEPTH coefficients
// across S banks; coefficient k -> bank k mod S, word k div S.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : begin one polynomial load (honoured only in IDLE)
//   bus          : coeff_bank_loader_if.slave (stream in, bank writes out)
//   o_busy_c     : high while loading (combinational from state)
//   o_done       : registered pulse coincident with the final bank write
// Optional: define COEFF_BANK_LOADER_MODQ_EN to reduce each input by one
// conditional subtraction of Q before it is written.
module coeff_bank_loader #(
    parameter int unsigned N     = 9,
    parameter int unsigned S     = 3,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned Q     = 257
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    coeff_bank_loader_if.slave       bus,
    output logic                     o_busy_c,
    output logic                     o_done
);
    localparam int unsigned SW = $clog2(S);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_accept;
    logic          w_load_entry;
    logic          w_last;
    logic [N-1:0]  w_data_in;

    logic [SW-1:0] r_bank;
    logic [AW-1:0] r_word;

    logic [SW-1:0] r_sel;
    logic [N-1:0]  r_bank_data;
    logic [S-1:0]  r_bank_we;
    logic [AW-1:0] r_bank_addr;
    logic          r_done;

    // Input path reduction
`ifdef COEFF_BANK_LOADER_MODQ_EN
    localparam logic [N-1:0] QN = N'(Q);
    assign w_data_in = (bus.in_data >= QN) ? (bus.in_data - QN) : bus.in_data;
`else
    assign w_data_in = bus.in_data;
    // Q only matters with the reduction compiled in; this just keeps it referenced.
    if (Q >= (64'd1 << N)) begin : g_q_exceeds_width
    end
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, acceptance and load-entry strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_load_entry = 1'b0;
        w_last       = (r_bank == SW'(S - 1)) && (r_word == AW'(DEPTH - 1));
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt  = ST_LOAD;
                    w_load_entry = 1'b1;
                end
            end
            ST_LOAD: begin
                w_accept = bus.in_valid;
                if (bus.in_valid && w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready_c = (r_state == ST_LOAD);
    assign o_busy_c       = (r_state == ST_LOAD);

    // Bank/word counters; the final acceptance leaves them parked since LOAD is exited
    always_ff @(posedge i_clk) begin
        if (i_rst || w_load_entry) begin
            r_bank <= '0;
            r_word <= '0;
        end else if (w_accept && !w_last) begin
            if (r_bank == SW'(S - 1)) begin
                r_bank <= '0;
                r_word <= r_word + AW'(1);
            end else begin
                r_bank <= r_bank + SW'(1);
            end
        end
    end

    // Registered bank write; sel/addr/data hold between writes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel       <= '0;
            r_bank_data <= '0;
            r_bank_we   <= '0;
            r_bank_addr <= '0;
            r_done      <= 1'b0;
        end else begin
            r_bank_we <= '0;
            r_done    <= w_accept && w_last;
            if (w_accept) begin
                r_bank_we   <= S'(1) << r_bank;
                r_sel       <= r_bank;
                r_bank_addr <= r_word;
                r_bank_data <= w_data_in;
            end
        end
    end

    assign bus.sel       = r_sel;
    assign bus.bank_data = r_bank_data;
    assign bus.bank_we   = r_bank_we;
    assign bus.bank_addr = r_bank_addr;
    assign o_done        = r_done;
endmodule

// File: tb/tb_coeff_bank_loader.sv
// Self-checking bench for coeff_bank_loader: directed stimulus with literal
// expectations plus a per-cycle comparison against a polynomial-level model.
module tb_coeff_bank_loader;
    localparam int unsigned N     = 9;
    localparam int unsigned S     = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned Q     = 257;
    localparam int unsigned L     = S * DEPTH;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy_c;
    logic done;

    always #5 clk = ~clk;

    coeff_bank_loader_if #(.N(N), .S(S), .DEPTH(DEPTH)) bus ();

    coeff_bank_loader #(.N(N), .S(S), .DEPTH(DEPTH), .Q(Q)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .bus      (bus.slave),
        .o_busy_c (busy_c),
        .o_done   (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int red(input int x);
`ifdef COEFF_BANK_LOADER_MODQ_EN
        return (x >= int'(Q)) ? x - int'(Q) : x;
`else
        return x;
`endif
    endfunction

    // Polynomial-level model: count of coefficients taken in the current load
    bit  m_armed   = 1'b0;
    bit  m_loading = 1'b0;
    bit  m_was_done;
    int  m_k       = 0;
    int  m_we      = 0;
    int  m_sel     = 0;
    int  m_addr    = 0;
    int  m_data    = 0;
    bit  m_done    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_loading = 1'b0;
            m_k       = 0;
            m_we      = 0;
            m_sel     = 0;
            m_addr    = 0;
            m_data    = 0;
            m_done    = 1'b0;
        end else begin
            m_was_done = m_done;
            m_we       = 0;
            m_done     = 1'b0;
            if (m_loading && bus.in_valid) begin
                m_we   = 1 << (m_k % S);
                m_sel  = m_k % S;
                m_addr = m_k / S;
                m_data = red(int'(bus.in_data));
                m_done = (m_k == L - 1);
                m_k++;
                if (m_k == L) m_loading = 1'b0;
            end else if (!m_loading && !m_was_done && start) begin
                m_loading = 1'b1;
                m_k       = 0;
            end
        end
        m_armed = 1'b1;
    end

    // Every-cycle compare, sampled mid-period
    always @(negedge clk) begin
        if (m_armed) begin
            chk("cyc_ready", 32'(bus.in_ready_c), 32'(m_loading));
            chk("cyc_busy",  32'(busy_c),         32'(m_loading));
            chk("cyc_we",    32'(bus.bank_we),    32'(m_we));
            chk("cyc_sel",   32'(bus.sel),        32'(m_sel));
            chk("cyc_addr",  32'(bus.bank_addr),  32'(m_addr));
            chk("cyc_data",  32'(bus.bank_data),  32'(m_data));
            chk("cyc_done",  32'(done),           32'(m_done));
        end
    end

    task automatic drive(input logic st, input logic v, input logic [N-1:0] d);
        start        = st;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int we_tab[12]   = '{1, 2, 4, 1, 2, 4, 1, 2, 4, 1, 2, 4};
        int addr_tab[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
        int bv_tab[6]    = '{1, 0, 0, 1, 0, 1};
        int bd_tab[6]    = '{7, 0, 0, 8, 0, 9};
        int bwe_tab[6]   = '{1, 0, 0, 2, 0, 4};
        int bsel_tab[6]  = '{0, 0, 0, 1, 1, 2};
        int bdat_tab[6]  = '{7, 7, 7, 8, 8, 9};
        int mq_in[4];
        int mq_exp[4];
        int mq_n;

        // Reset with start and in_valid asserted
        rst = 1'b1;
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 9'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(bus.in_ready_c), 0);
        chk("rst_busy",  32'(busy_c), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_we",    32'(bus.bank_we), 0);
        chk("rst_sel",   32'(bus.sel), 0);
        chk("rst_addr",  32'(bus.bank_addr), 0);
        chk("rst_data",  32'(bus.bank_data), 0);
        rst = 1'b0;

        // Full load, data 1..12, no bubbles
        drive(1'b1, 1'b0, 9'd0);
        chk("full_ready_after_start", 32'(bus.in_ready_c), 1);
        for (int i = 1; i <= 12; i++) begin
            drive(1'b0, 1'b1, N'(i));
            chk("full_we",   32'(bus.bank_we), 32'(we_tab[i-1]));
            chk("full_addr", 32'(bus.bank_addr), 32'(addr_tab[i-1]));
            chk("full_data", 32'(bus.bank_data), 32'(i));
            chk("full_done", 32'(done), (i == 12) ? 1 : 0);
        end
        chk("full_ready_in_done", 32'(bus.in_ready_c), 0);
        chk("full_sel_last", 32'(bus.sel), 2);
        drive(1'b0, 1'b0, 9'd0);
        chk("full_we_idle", 32'(bus.bank_we), 0);
        chk("full_done_once", 32'(done), 0);

        // Bubbles in the stream
        drive(1'b1, 1'b0, 9'd0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'(bv_tab[i]), N'(bd_tab[i]));
            chk("bub_we",   32'(bus.bank_we), 32'(bwe_tab[i]));
            chk("bub_sel",  32'(bus.sel), 32'(bsel_tab[i]));
            chk("bub_addr", 32'(bus.bank_addr), 0);
            chk("bub_data", 32'(bus.bank_data), 32'(bdat_tab[i]));
        end
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, N'(100 + i));
        chk("bub_done", 32'(done), 1);
        drive(1'b0, 1'b0, 9'd0);

        // start ignored during LOAD and in DONE
        drive(1'b1, 1'b0, 9'd0);
        for (int i = 0; i < 12; i++) drive(i == 2, 1'b1, N'(30 + i));
        chk("ign_done", 32'(done), 1);
        chk("ign_last_data", 32'(bus.bank_data), 41);
        drive(1'b1, 1'b1, 9'd99);
        chk("ign_ready_after_done_start", 32'(bus.in_ready_c), 0);
        chk("ign_we_after_done_start", 32'(bus.bank_we), 0);
        drive(1'b0, 1'b1, 9'd98);
        chk("ign_ready_idle", 32'(bus.in_ready_c), 0);
        chk("ign_we_idle", 32'(bus.bank_we), 0);

        // Reset in the middle of a load
        drive(1'b1, 1'b0, 9'd0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, N'(50 + i));
        chk("mid_addr_before_rst", 32'(bus.bank_addr), 1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 9'd77);
        chk("mid_we",    32'(bus.bank_we), 0);
        chk("mid_sel",   32'(bus.sel), 0);
        chk("mid_addr",  32'(bus.bank_addr), 0);
        chk("mid_data",  32'(bus.bank_data), 0);
        chk("mid_done",  32'(done), 0);
        chk("mid_ready", 32'(bus.in_ready_c), 0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 9'd0);
        drive(1'b0, 1'b1, 9'd20);
        chk("mid_restart_we",   32'(bus.bank_we), 1);
        chk("mid_restart_sel",  32'(bus.sel), 0);
        chk("mid_restart_addr", 32'(bus.bank_addr), 0);
        chk("mid_restart_data", 32'(bus.bank_data), 20);
        drive(1'b0, 1'b1, 9'd21);
        chk("mid_restart_sel2", 32'(bus.sel), 1);

        // Input reduction (or pass-through)
        rst = 1'b1;
        drive(1'b0, 1'b0, 9'd0);
        rst = 1'b0;
`ifdef COEFF_BANK_LOADER_MODQ_EN
        mq_in  = '{300, 256, 257, 0};
        mq_exp = '{43, 256, 0, 0};
        mq_n   = 4;
`else
        mq_in  = '{300, 257, 0, 0};
        mq_exp = '{300, 257, 0, 0};
        mq_n   = 2;
`endif
        drive(1'b1, 1'b0, 9'd0);
        for (int i = 0; i < mq_n; i++) begin
            drive(1'b0, 1'b1, N'(mq_in[i]));
            chk("modq_data", 32'(bus.bank_data), 32'(mq_exp[i]));
        end

        rst = 1'b1;
        drive(1'b0, 1'b0, 9'd0);
        drive(1'b0, 1'b0, 9'd0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/coeff_bank_loader.md
Name: coeff_bank_loader

Overview:
- Upstream feeder for the polynomial-bank demux in the NTT datapath.
- Accepts a serial coefficient stream over a valid/ready handshake and distributes it round-robin across S memory banks.
- Drives the demux select together with matching per-bank write strobes and word addresses.
- One polynomial of S*DEPTH coefficients per start command: coefficient k goes to bank k mod S at address k div S.

Parameters:
- N, 9, coefficient width in bits.
- S, 3, number of banks (demux outputs); S >= 2.
- DEPTH, 4, words per bank; DEPTH >= 2; polynomial length L = S*DEPTH.
- Q, 257, modulus; used only when the optional feature is compiled in; Q < 2^N.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin loading one polynomial; honoured only in IDLE.
- in_valid  in  1  in_data valid.
- in_data  in  N  input coefficient.
- in_ready  out  1  loader can accept a coefficient.
- sel  out  $clog2(S)  bank select to demux.
- bank_data  out  N  coefficient to demux input.
- bank_we  out  S  one-hot write strobe; bit i = bank i.
- bank_addr  out  $clog2(DEPTH)  word address within the selected bank.
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse marking the final write.

Behaviour:
- States: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start.
  - LOAD -> DONE on acceptance of coefficient L-1.
  - DONE -> IDLE unconditionally after one cycle.
- Handshake and state-derived outputs:
  - in_ready = (state==LOAD), combinational from state.
  - Acceptance is in_valid & in_ready. in_data is ignored otherwise.
  - busy = (state==LOAD), combinational from state.
- Counters:
  - bank counter b (0..S-1) and address counter a (0..DEPTH-1) clear on entry to LOAD.
  - On each acceptance: if b==S-1 then b=0, a=a+1; else b=b+1. Neither counter wraps past the last word, because the FSM leaves LOAD.
  - Counters hold on cycles without acceptance (bubbles).
- Outputs:
  - Registered; latency 1 cycle from acceptance.
  - bank_we = one-hot(b), sel = b, bank_addr = a, bank_data = in_data (reduced if the feature is enabled), all taken from the accepting cycle.
  - bank_we is 0 in every cycle not following an acceptance.
  - sel, bank_addr and bank_data hold their last values between writes.
- done:
  - Registered, asserted in the same cycle as the bank_we for coefficient L-1, i.e. the cycle the FSM is in DONE.
  - Exactly one pulse per polynomial.
- start handling:
  - Ignored in LOAD and DONE; no effect on counters.
  - Asserting start in the DONE cycle does not start a new load; start must be re-asserted in IDLE.
- Reset:
  - All outputs 0 and state IDLE on the clock edge where rst=1.
  - Applies at any point including mid-LOAD. A partial polynomial is abandoned with no further bank_we.
  - rst dominates start and in_valid.
  - Next load after reset begins at bank 0, address 0.

Optional Feature:
- Macro COEFF_BANK_LOADER_MODQ_EN.
- Defined: one conditional subtraction on the input path: bank_data = (in_data >= Q) ? in_data - Q : in_data, evaluated in N bits. Latency unchanged (still 1 cycle).
- Undefined: bank_data = in_data unmodified; Q unused; no comparator or subtractor synthesised.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1, in_valid=1 -> in_ready=0, busy=0, done=0, bank_we=000, sel=0, bank_addr=0, bank_data=0.
- Full load, S=3, DEPTH=4, in_valid held high, data 1..12 after start:
  - bank_we cycles 001,010,100 four times; sel 0,1,2 repeating; bank_addr 0,0,0,1,1,1,2,2,2,3,3,3; bank_data 1..12 one cycle after each acceptance.
  - done=1 only with the write of 12; in_ready=0 the cycle after the 12th acceptance.
- Bubbles: in_valid pattern 1,0,0,1,0,1 with data 7,x,x,8,x,9 -> exactly three writes (bank 0/addr 0=7, bank 1/addr 0=8, bank 2/addr 0=9); bank_we=000 in bubble cycles; counters unchanged across bubbles.
- start ignored: pulse start in the 3rd LOAD cycle and in the DONE cycle -> sequence unaffected, state returns to IDLE, in_ready=0 until a fresh start in IDLE.
- Reset mid-load: assert rst after 5 accepted coefficients -> next cycle all outputs 0, no done; new start with data 20.. writes 20 to bank 0 addr 0.
- Mod-Q (macro defined, Q=257): inputs 300, 256, 257, 0 -> bank_data 43, 256, 0, 0. With macro undefined: 300 -> 300, 257 -> 257.
